// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extension stage (zero/sign/shift-merge/load-high) with a 2-entry valid/ready output buffer.
// Ports: clk, rst_n (async active-low), flush (sync clear of buffer and accumulator),
//        in_valid/in_ready/in_imm/in_mode upstream handshake, out_valid/out_ready/out_data downstream handshake.
// Optional IMM_EXT_OVF_FLAG_EN adds out_ovf, a per-entry flag marking significant bits lost by shift-merge or load-high.
module imm_ext_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_OVF_FLAG_EN
  ,
  output logic             out_ovf
`endif
);
`ifdef IMM_EXT_OVF_FLAG_EN
  localparam int ACC_W = OUT_W;
`else
  // Without the flag only the bits that shift-merge carries forward are ever observable.
  localparam int ACC_W = OUT_W - IN_W;
`endif
  logic [1:0]       count_q, count_d;
  logic             hd_q, hd_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic             push, pop, tl;
  logic [OUT_W-1:0] zx, sx, sm, lh, res;
`ifdef IMM_EXT_OVF_FLAG_EN
  logic             ovf_q [2];
  logic             ovf_d [2];
  logic             res_ovf;
  logic [OUT_W+IN_W-1:0] lh_w;
`endif
  assign in_ready  = count_q != 2'd2;
  assign out_valid = count_q != 2'd0;
  assign out_data  = mem_q[hd_q];
`ifdef IMM_EXT_OVF_FLAG_EN
  assign out_ovf   = ovf_q[hd_q];
`endif
  always_comb begin
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
    // Tail slot is the head when empty, the other slot when one entry is held.
    tl   = hd_q ^ count_q[0];
    zx   = {{(OUT_W-IN_W){1'b0}}, in_imm};
    sx   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    sm   = {acc_q[OUT_W-IN_W-1:0], in_imm};
`ifdef IMM_EXT_OVF_FLAG_EN
    // Widened shift keeps any bits pushed past OUT_W visible for the flag.
    lh_w    = {{OUT_W{1'b0}}, in_imm} << (OUT_W - IN_W);
    lh      = lh_w[OUT_W-1:0];
    res_ovf = in_mode == 2'd2 ? |acc_q[OUT_W-1:OUT_W-IN_W] :
              in_mode == 2'd3 ? |lh_w[OUT_W+IN_W-1:OUT_W] : 1'b0;
`else
    lh   = {in_imm, {(OUT_W-IN_W){1'b0}}};
`endif
    res  = in_mode == 2'd0 ? zx :
           in_mode == 2'd1 ? sx :
           in_mode == 2'd2 ? sm : lh;
    count_d = flush ? 2'd0 : 2'(count_q + {1'b0, push} - {1'b0, pop});
    hd_d    = flush ? hd_q : hd_q ^ pop;
    acc_d   = flush ? '0 : push ? res[ACC_W-1:0] : acc_q;
    mem_d   = mem_q;
    if (push && !flush) mem_d[tl] = res;
`ifdef IMM_EXT_OVF_FLAG_EN
    ovf_d   = ovf_q;
    if (flush) ovf_d = '{default: 1'b0};
    else if (push) ovf_d[tl] = res_ovf;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hd_q    <= 1'b0;
      acc_q   <= '0;
      mem_q   <= '{default: '0};
`ifdef IMM_EXT_OVF_FLAG_EN
      ovf_q   <= '{default: 1'b0};
`endif
    end else begin
      count_q <= count_d;
      hd_q    <= hd_d;
      acc_q   <= acc_d;
      mem_q   <= mem_d;
`ifdef IMM_EXT_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench for imm_ext_pipe (IN_W=8, OUT_W=16).
module tb_imm_ext_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
`ifdef IMM_EXT_OVF_FLAG_EN
  logic        out_ovf;
`endif
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] acc_m = '0;
  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef IMM_EXT_OVF_FLAG_EN
    , .out_ovf(out_ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] ext(input logic [1:0] m, input logic [7:0] d, input logic [15:0] a);
    case (m)
      2'd0: return {8'h00, d};
      2'd1: return {{8{d[7]}}, d};
      2'd2: return {a[7:0], d};
      default: return {d, 8'h00};
    endcase
  endfunction
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n || flush) begin
      exp_q.delete();
      acc_m = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_empty", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("data", {16'h0, out_data}, {16'h0, e});
        end
      end
      if (in_valid && in_ready) begin
        e = ext(in_mode, in_imm, acc_m);
        acc_m = e;
        exp_q.push_back(e);
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic [7:0] d);
    int n = 0;
    in_mode = m;
    in_imm = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", {31'h0, out_valid}, 32'd0);
  endtask
  initial begin
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_data", {16'h0, out_data}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(2'd1, 8'h80);
    chk("lat_valid", {31'h0, out_valid}, 32'd1);
    chk("sext", {16'h0, out_data}, 32'h0000FF80);
    send(2'd0, 8'h80);
    chk("zext", {16'h0, out_data}, 32'h00000080);
    send(2'd3, 8'h12);
    chk("loadhi", {16'h0, out_data}, 32'h00001200);
    send(2'd2, 8'h34);
    send(2'd0, 8'h56);
    send(2'd2, 8'h78);
    drain();
    out_ready = 1'b0;
    send(2'd0, 8'h01);
    send(2'd0, 8'h02);
    fork
      send(2'd0, 8'h03);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", {31'h0, in_ready}, 32'd0);
          chk("stall_valid", {31'h0, out_valid}, 32'd1);
          chk("stall_data", {16'h0, out_data}, 32'h00000001);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    send(2'd0, 8'h05);
    send(2'd0, 8'h06);
    chk("full_ready", {31'h0, in_ready}, 32'd0);
    in_mode = 2'd0;
    in_imm = 8'h07;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'h0, out_valid}, 32'd0);
    chk("flush_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(2'd2, 8'hAB);
    chk("flush_acc", {16'h0, out_data}, 32'h000000AB);
    drain();
    out_ready = 1'b0;
    send(2'd0, 8'h09);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'd0);
    chk("arst_ready", {31'h0, in_ready}, 32'd1);
    chk("arst_data", {16'h0, out_data}, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'd1);
    chk("post_rst_data", {16'h0, out_data}, 32'h0);
    out_ready = 1'b1;
    send(2'd0, 8'h42);
    chk("post_rst_first", {16'h0, out_data}, 32'h00000042);
    fork
      for (int i = 0; i < 40; i++) send(2'($urandom_range(0, 3)), 8'($urandom));
      begin
        for (int j = 0; j < 120; j++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    chk("end_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
